// File: rtl/board_pkg.sv
// Shared definitions for the minesweeper board renderer.
// Holds the tile geometry, the 3-bit {R,G,B} palette, the FSM state
// encoding, the per-tile status record, and helpers that return the
// top-left pixel of a tile's column and row.
package board_pkg;

  localparam int TILE_W      = 19;  // drawn tile width in pixels
  localparam int TILE_H      = 14;  // drawn tile height in pixels
  localparam int PITCH_X     = 20;  // horizontal pitch (1-px gap)
  localparam int PITCH_Y     = 15;  // vertical pitch (1-px gap)
  localparam int BOARD_TILES = 64;

  localparam logic [2:0] COL_HIDDEN = 3'b111;  // white
  localparam logic [2:0] COL_SAFE   = 3'b010;  // green
  localparam logic [2:0] COL_FLAG   = 3'b110;  // yellow
  localparam logic [2:0] COL_BOOM   = 3'b100;  // red
  localparam logic [2:0] COL_MINE   = 3'b101;  // magenta
  localparam logic [2:0] COL_CURSOR = 3'b001;  // blue

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Status of the tile currently being painted, latched once per tile
  typedef struct packed {
    logic mine;
    logic flag;
    logic step;
    logic is_cursor;
  } tile_stat_t;

  // Left-most pixel column of a tile column (max 7*20 = 140)
  function automatic logic [7:0] tile_x0(input logic [2:0] col);
    return 8'(col) * 8'(PITCH_X);
  endfunction

  // Top-most pixel row of a tile row (max 7*15 = 105)
  function automatic logic [6:0] tile_y0(input logic [2:0] row);
    return 7'(row) * 7'(PITCH_Y);
  endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Bundle between the game-state logic / frame buffer and the renderer.
//   master : game-state side (drives start and the maps, observes status)
//   slave  : renderer side (samples the maps, drives the pixel write port)
// Signals: start, mine_map/flag_map/step_map[63:0], cursor[5:0],
//          reveal_all, x[7:0], y[6:0], colour[2:0], plot, busy, done.
interface board_renderer_if;
  logic        start;
  logic [63:0] mine_map;
  logic [63:0] flag_map;
  logic [63:0] step_map;
  logic [5:0]  cursor;
  logic        reveal_all;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output start, mine_map, flag_map, step_map, cursor, reveal_all,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mine_map, flag_map, step_map, cursor, reveal_all,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/board_tile_colour.sv
// Combinational colour picker for one pixel of a tile.
// Ports:
//   i_mine, i_flag, i_step : tile status bits
//   i_is_cursor            : tile is under the player cursor
//   i_on_border            : pixel is on the tile's outer ring
//   i_reveal_all           : game over, show every mine
//   o_colour               : {R,G,B}
module board_tile_colour
  import board_pkg::*;
(
  input  logic       i_mine,
  input  logic       i_flag,
  input  logic       i_step,
  input  logic       i_is_cursor,
  input  logic       i_on_border,
  input  logic       i_reveal_all,
  output logic [2:0] o_colour
);
  // First match wins. A flag on a stepped tile is stale, so stepped
  // takes over from flagged.
  always_comb begin
    o_colour = COL_HIDDEN;
    if (i_is_cursor && i_on_border)  o_colour = COL_CURSOR;
    else if (i_mine && i_step)       o_colour = COL_BOOM;
    else if (i_mine && i_reveal_all) o_colour = COL_MINE;
    else if (i_flag && !i_step)      o_colour = COL_FLAG;
    else if (i_step)                 o_colour = COL_SAFE;
  end
endmodule

// File: rtl/board_renderer.sv
// Full-frame tile painter for the 8x8 minesweeper board on a 160x120
// 3-bit frame buffer. A start pulse snapshots the maps, then all 64
// tiles are walked, one pixel write per cycle, followed by a done pulse.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : board_renderer_if.slave (start, maps, cursor, reveal_all in;
//            x, y, colour, plot, busy, done out)
module board_renderer
  import board_pkg::*;
(
  input logic              clk,
  input logic              resetn,
  board_renderer_if.slave  bus
);

  state_t      r_state;
  logic [63:0] r_mine_map, r_flag_map, r_step_map;
  logic [5:0]  r_cursor;
  logic        r_reveal;
  logic [5:0]  r_tile;
  tile_stat_t  r_stat;
  logic [4:0]  r_px;
  logic [3:0]  r_py;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot, r_busy, r_done;

  logic        w_last_px, w_last_py, w_on_border;
  logic [2:0]  w_colour;

  assign w_last_px   = (r_px == 5'(TILE_W - 1));
  assign w_last_py   = (r_py == 4'(TILE_H - 1));
  assign w_on_border = (r_px == '0) || w_last_px || (r_py == '0) || w_last_py;

  board_tile_colour u_colour (
    .i_mine       (r_stat.mine),
    .i_flag       (r_stat.flag),
    .i_step       (r_stat.step),
    .i_is_cursor  (r_stat.is_cursor),
    .i_on_border  (w_on_border),
    .i_reveal_all (r_reveal),
    .o_colour     (w_colour)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_mine_map <= '0;
      r_flag_map <= '0;
      r_step_map <= '0;
      r_cursor   <= '0;
      r_reveal   <= 1'b0;
      r_tile     <= '0;
      r_stat     <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      r_plot     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mine_map <= bus.mine_map;
            r_flag_map <= bus.flag_map;
            r_step_map <= bus.step_map;
            r_cursor   <= bus.cursor;
            r_reveal   <= bus.reveal_all;
            r_tile     <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // One plot-low cycle per tile while its status is latched
          r_stat.mine      <= r_mine_map[r_tile];
          r_stat.flag      <= r_flag_map[r_tile];
          r_stat.step      <= r_step_map[r_tile];
          r_stat.is_cursor <= (r_tile == r_cursor);
          r_px             <= '0;
          r_py             <= '0;
          r_plot           <= 1'b0;
          r_state          <= S_DRAW;
        end
        S_DRAW: begin
          r_plot   <= 1'b1;
          r_x      <= tile_x0(r_tile[2:0]) + 8'(r_px);
          r_y      <= tile_y0(r_tile[5:3]) + 7'(r_py);
          r_colour <= w_colour;
          if (!w_last_px) begin
            r_px <= r_px + 5'd1;
          end else begin
            r_px <= '0;
            if (!w_last_py) begin
              r_py <= r_py + 4'd1;
            end else begin
              r_py <= '0;
              if (r_tile == 6'(BOARD_TILES - 1)) begin
                r_state <= S_FIN;
              end else begin
                r_tile  <= r_tile + 6'd1;
                r_state <= S_LOAD;
              end
            end
          end
        end
        S_FIN: begin
          // start seen here is dropped; IDLE accepts on the next edge
          r_plot  <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_board_renderer.sv
module tb_board_renderer;

  localparam int NPIX    = 64 * 19 * 14;  // 17024 writes per frame
  localparam int DONE_AT = 17089;         // edges from start sample to done
  localparam int M_CHG     = 1;  // step_map -> all ones 10 cycles after start
  localparam int M_RESTART = 2;  // second start pulse at cycle 5000
  localparam int M_ONDONE  = 4;  // start asserted on the done edge

  typedef struct {
    logic [63:0] mine, flag, step;
    int          cursor;
    bit          reveal;
    int          mode;
  } scen_t;

  typedef struct {
    int sc;
    int x, y;
    int col;  // -1 : pixel must never be written
  } probe_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  board_renderer_if bus();
  board_renderer dut (.clk(clk), .resetn(resetn), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] s_mine, s_flag, s_step;
  int          s_cur;
  bit          s_rev;
  int exp_x[NPIX], exp_y[NPIX], exp_c[NPIX];

  function automatic int model_col(int t, int px, int py);
    if (t == s_cur && (px == 0 || px == 18 || py == 0 || py == 13)) return 1;
    if (s_mine[t] && s_step[t]) return 4;
    if (s_mine[t] && s_rev)     return 5;
    if (s_flag[t] && !s_step[t]) return 6;
    if (s_step[t])              return 2;
    return 7;
  endfunction

  task automatic build_expected();
    int k = 0;
    for (int t = 0; t < 64; t++)
      for (int py = 0; py < 14; py++)
        for (int px = 0; px < 19; px++) begin
          exp_x[k] = (t % 8) * 20 + px;
          exp_y[k] = (t / 8) * 15 + py;
          exp_c[k] = model_col(t, px, py);
          k++;
        end
  endtask

  // ---------------- monitor ----------------
  bit mon_on = 0;
  int plots, dones, done_cyc, seq_idx, seq_err, hold_err, first_bad;
  int last_x, last_y, last_c;
  int dut_img[160][120];

  always @(negedge clk) if (mon_on) begin
    if (bus.plot) begin
      if (seq_idx >= NPIX || int'(bus.x) != exp_x[seq_idx] ||
          int'(bus.y) != exp_y[seq_idx] || int'(bus.colour) != exp_c[seq_idx]) begin
        if (seq_err == 0) first_bad = seq_idx;
        seq_err++;
      end
      if (bus.x < 160 && bus.y < 120) dut_img[bus.x][bus.y] = int'(bus.colour);
      last_x = int'(bus.x); last_y = int'(bus.y); last_c = int'(bus.colour);
      seq_idx++;
      plots++;
    end else if ((bus.busy || bus.done) && plots > 0) begin
      if (int'(bus.x) != last_x || int'(bus.y) != last_y || int'(bus.colour) != last_c)
        hold_err++;
    end
    if (bus.done) begin
      dones++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    plots = 0; dones = 0; done_cyc = -1; seq_idx = 0; seq_err = 0;
    hold_err = 0; first_bad = -1;
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++) dut_img[i][j] = -1;
  endtask

  task automatic load_scen(input scen_t sc);
    bus.mine_map = sc.mine; bus.flag_map = sc.flag; bus.step_map = sc.step;
    bus.cursor = 6'(sc.cursor); bus.reveal_all = sc.reveal;
    s_mine = sc.mine; s_flag = sc.flag; s_step = sc.step;
    s_cur = sc.cursor; s_rev = sc.reveal;
    build_expected();
    clear_mon();
  endtask

  task automatic run_frame(input scen_t sc, input string tag);
    int s_edge;
    load_scen(sc);
    mon_on = 1;
    @(negedge clk);
    bus.start = 1'b1;
    s_edge = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < s_edge + DONE_AT + 6) begin
      @(negedge clk);
      if ((sc.mode & M_CHG) != 0 && cyc == s_edge + 10) bus.step_map = '1;
      if ((sc.mode & M_RESTART) != 0) begin
        if (cyc == s_edge + 4999) bus.start = 1'b1;
        if (cyc == s_edge + 5000) bus.start = 1'b0;
      end
      if ((sc.mode & M_ONDONE) != 0) begin
        if (cyc == s_edge + DONE_AT - 1) bus.start = 1'b1;
        if (cyc == s_edge + DONE_AT)     bus.start = 1'b0;
      end
    end
    mon_on = 0;
    chk({tag, " plot_count"}, plots, NPIX);
    chk({tag, " done_count"}, dones, 1);
    chk({tag, " done_latency"}, done_cyc - s_edge, DONE_AT);
    chk({tag, " write_sequence_errors"}, seq_err, 0);
    if (seq_err != 0)
      $display("  %s first bad write index %0d: x=%0d y=%0d col=%0d wanted", tag,
               first_bad, exp_x[first_bad], exp_y[first_bad], exp_c[first_bad]);
    chk({tag, " hold_when_idle_errors"}, hold_err, 0);
    chk({tag, " busy_after_frame"}, int'(bus.busy), 0);
  endtask

  scen_t  scen[3];
  probe_t probes[$];

  initial begin
    scen_t rs;
    int    s_edge;

    scen[0] = '{mine: 64'd0, flag: 64'd0, step: 64'd0, cursor: 0, reveal: 1'b0,
                mode: M_CHG | M_ONDONE};
    scen[1] = '{mine: 64'd1 << 9, flag: 64'd0, step: 64'd1 << 9, cursor: 63,
                reveal: 1'b0, mode: M_RESTART};
    scen[2] = '{mine: 64'd1, flag: 64'd2, step: 64'd0, cursor: 63, reveal: 1'b1,
                mode: 0};

    probes = '{
      '{0, 0, 0, 1},    '{0, 1, 1, 7},    '{0, 158, 118, 7}, '{0, 18, 13, 1},
      '{0, 19, 0, -1},  '{0, 20, 0, 7},   '{0, 0, 14, -1},   '{0, 159, 119, -1},
      '{1, 20, 15, 4},  '{1, 38, 28, 4},  '{1, 29, 20, 4},   '{1, 39, 15, -1},
      '{1, 0, 0, 7},    '{1, 158, 118, 1},
      '{2, 5, 5, 5},    '{2, 0, 0, 5},    '{2, 20, 0, 6},    '{2, 38, 13, 6},
      '{2, 40, 0, 7}
    };

    bus.start = 1'b0; bus.mine_map = '0; bus.flag_map = '0; bus.step_map = '0;
    bus.cursor = '0; bus.reveal_all = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset x", int'(bus.x), 0);
    chk("reset y", int'(bus.y), 0);
    chk("reset colour", int'(bus.colour), 0);
    chk("reset plot", int'(bus.plot), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven frames with spot-pixel probes
    for (int s = 0; s < 3; s++) begin
      run_frame(scen[s], $sformatf("frame%0d", s));
      foreach (probes[i])
        if (probes[i].sc == s)
          chk($sformatf("frame%0d pixel(%0d,%0d)", s, probes[i].x, probes[i].y),
              dut_img[probes[i].x][probes[i].y], probes[i].col);
    end

    // mid-frame asynchronous reset
    rs = '{mine: {$urandom, $urandom}, flag: {$urandom, $urandom},
           step: {$urandom, $urandom}, cursor: int'($urandom_range(0, 63)),
           reveal: 1'($urandom_range(0, 1)), mode: 0};
    load_scen(rs);
    mon_on = 1;
    @(negedge clk);
    bus.start = 1'b1;
    s_edge = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < s_edge + 3000) @(negedge clk);
    chk("abort busy_before_reset", int'(bus.busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("abort plot", int'(bus.plot), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    chk("abort x", int'(bus.x), 0);
    chk("abort y", int'(bus.y), 0);
    chk("abort colour", int'(bus.colour), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    mon_on = 0;
    chk("abort no_done_pulse", dones, 0);
    chk("abort idle_after_release", int'(bus.busy), 0);

    // random maps, full frame after the abort
    rs = '{mine: {$urandom, $urandom}, flag: {$urandom, $urandom},
           step: {$urandom, $urandom}, cursor: int'($urandom_range(0, 63)),
           reveal: 1'b1, mode: 0};
    run_frame(rs, "random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
